cachevictimbuf: RTL and testbench

Dirty-victim writeback buffer for the set-associative cache. It sits directly downstream of the replacement-policy block and consumes its one-hot VictimWay. On an eviction request it selects the victim way's line, tag and dirty bit and, if dirty, snapshots the line into a local buffer. It then drains that line to the bus as WORDLEN-wide beats under a request/acknowledge handshake, which frees the cache array to accept the refill immediately.

---
 rtl/cachevictimbuf.sv | 123 ++++++++++++
 tb/tb_cachevictimbuf.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cachevictimbuf.sv
// Dirty-victim writeback buffer: snapshots a dirty victim line on eviction and
// drains it to the bus as WORDLEN-wide beats under a req/ack handshake.
module cachevictimbuf #(
  parameter int NUMWAYS   = 4,
  parameter int LINELEN   = 256,
  parameter int WORDLEN   = 64,
  parameter int SETLEN    = 7,
  parameter int TAGLEN    = 20,
  parameter int OFFSETLEN = 5,
  parameter int PA_BITS   = TAGLEN + SETLEN + OFFSETLEN
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         Evict,
  input  logic [NUMWAYS-1:0]           VictimWay,
  input  logic [NUMWAYS-1:0]           DirtyWay,
  input  logic [NUMWAYS*TAGLEN-1:0]    TagWay,
  input  logic [NUMWAYS*LINELEN-1:0]   ReadDataLineWay,
  input  logic [SETLEN-1:0]            CacheSet,
  output logic                         EvictReady,
  output logic                         EvictDirty,
  output logic                         BusReq,
  output logic [PA_BITS-1:0]           BusAdr,
  output logic [WORDLEN-1:0]           BusWData,
  output logic                         BusLast,
  input  logic                         BusAck,
  input  logic [PA_BITS-1:0]           ProbeAdr,
  output logic                         ProbeHit
);

  localparam int NBEATS = LINELEN / WORDLEN;
  localparam int BEATW  = $clog2(NBEATS);
  localparam int BYTEW  = OFFSETLEN - BEATW;
  localparam logic [BEATW-1:0] LAST_BEAT = BEATW'(NBEATS - 1);

  typedef enum logic {IDLE, DRAIN} state_e;

  state_e                             state_q, state_d;
  logic [BEATW-1:0]                   beat_q, beat_d;
  logic [NBEATS-1:0][WORDLEN-1:0]     line_q;
  logic [TAGLEN-1:0]                  tag_q;
  logic [SETLEN-1:0]                  set_q;
  logic [LINELEN-1:0]                 sel_line;
  logic [TAGLEN-1:0]                  sel_tag;
  logic                               capture;
  logic                               unused_probe_ofs;

  // One-hot AND-OR victim mux; an all-zero VictimWay selects nothing.
  always_comb begin
    sel_line = '0;
    sel_tag  = '0;
    for (int i = 0; i < NUMWAYS; i++) begin
      sel_line = sel_line | (ReadDataLineWay[i*LINELEN +: LINELEN] & {LINELEN{VictimWay[i]}});
      sel_tag  = sel_tag  | (TagWay[i*TAGLEN +: TAGLEN] & {TAGLEN{VictimWay[i]}});
    end
  end

  assign EvictDirty = |(VictimWay & DirtyWay);

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    capture    = 1'b0;
    EvictReady = 1'b0;
    BusReq     = 1'b0;
    case (state_q)
      IDLE: begin
        EvictReady = 1'b1;
        if (Evict && EvictDirty) begin
          capture = 1'b1;
          beat_d  = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        BusReq = 1'b1;
        if (BusAck) begin
          if (BusLast) begin
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Snapshot is private: later array writes cannot disturb an in-flight drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_q <= '0;
      tag_q  <= '0;
      set_q  <= '0;
    end else if (capture) begin
      line_q <= sel_line;
      tag_q  <= sel_tag;
      set_q  <= CacheSet;
    end
  end

  assign BusLast  = (state_q == DRAIN) && (beat_q == LAST_BEAT);
  assign BusAdr   = {tag_q, set_q, beat_q, {BYTEW{1'b0}}};
  assign BusWData = line_q[beat_q];
  assign ProbeHit = (state_q == DRAIN) && (ProbeAdr[PA_BITS-1:OFFSETLEN] == {tag_q, set_q});

  assign unused_probe_ofs = ^ProbeAdr[OFFSETLEN-1:0];

  a_victim_onehot: assert property (@(posedge clk) disable iff (reset)
    Evict |-> $onehot0(VictimWay));

endmodule

// File: tb/tb_cachevictimbuf.sv
// Directed self-checking bench for cachevictimbuf with hand-computed beats.
module tb_cachevictimbuf;

  logic          clk;
  logic          reset;
  logic          Evict;
  logic [3:0]    VictimWay;
  logic [3:0]    DirtyWay;
  logic [79:0]   TagWay;
  logic [1023:0] ReadDataLineWay;
  logic [6:0]    CacheSet;
  logic          EvictReady;
  logic          EvictDirty;
  logic          BusReq;
  logic [31:0]   BusAdr;
  logic [63:0]   BusWData;
  logic          BusLast;
  logic          BusAck;
  logic [31:0]   ProbeAdr;
  logic          ProbeHit;

  int total = 0;
  int bad   = 0;

  cachevictimbuf dut (
    .clk(clk), .reset(reset), .Evict(Evict), .VictimWay(VictimWay),
    .DirtyWay(DirtyWay), .TagWay(TagWay), .ReadDataLineWay(ReadDataLineWay),
    .CacheSet(CacheSet), .EvictReady(EvictReady), .EvictDirty(EvictDirty),
    .BusReq(BusReq), .BusAdr(BusAdr), .BusWData(BusWData), .BusLast(BusLast),
    .BusAck(BusAck), .ProbeAdr(ProbeAdr), .ProbeHit(ProbeHit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Word w of way's line for data generation gen: recognisable per way/word/gen.
  function automatic logic [63:0] wd(input int way, input int w, input int gen);
    return {16'hCAFE, gen[7:0], way[7:0], 24'h0, w[7:0]};
  endfunction

  task automatic load(input int gen);
    for (int way = 0; way < 4; way++)
      for (int w = 0; w < 4; w++)
        ReadDataLineWay[way*256 + w*64 +: 64] = wd(way, w, gen);
  endtask

  task automatic chkbeat(input string tag, input logic [31:0] adr, input logic [63:0] data,
                         input logic last);
    chk({tag, ".req"},   {63'b0, BusReq},     64'd1);
    chk({tag, ".adr"},   {32'b0, BusAdr},     {32'b0, adr});
    chk({tag, ".data"},  BusWData,            data);
    chk({tag, ".last"},  {63'b0, BusLast},    {63'b0, last});
    chk({tag, ".ready"}, {63'b0, EvictReady}, 64'd0);
  endtask

  task automatic chkidle(input string tag);
    chk({tag, ".req"},   {63'b0, BusReq},     64'd0);
    chk({tag, ".ready"}, {63'b0, EvictReady}, 64'd1);
    chk({tag, ".last"},  {63'b0, BusLast},    64'd0);
  endtask

  initial begin
    reset = 1'b1; Evict = 1'b0; VictimWay = '0; DirtyWay = '0; BusAck = 1'b0;
    ProbeAdr = '0; CacheSet = '0;
    TagWay = {20'h00F0F, 20'h0ABCD, 20'h12345, 20'h11111};
    load(0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // reset state, idle 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chkidle("idle");
      chk("idle.probe", {63'b0, ProbeHit}, 64'd0);
      if (i == 0) begin
        chk("rst.adr",  {32'b0, BusAdr}, 64'd0);
        chk("rst.data", BusWData, 64'd0);
      end
    end

    // clean victim: no capture
    VictimWay = 4'b0100; DirtyWay = 4'b0011; Evict = 1'b1;
    #1 chk("clean.dirty", {63'b0, EvictDirty}, 64'd0);
    @(negedge clk);
    chkidle("clean");
    Evict = 1'b0;

    // dirty evict of way 1, back-to-back acks
    VictimWay = 4'b0010; DirtyWay = 4'b0010; CacheSet = 7'h05; BusAck = 1'b1; Evict = 1'b1;
    #1 chk("d1.dirty", {63'b0, EvictDirty}, 64'd1);
    chk("d1.ready0", {63'b0, EvictReady}, 64'd1);
    @(negedge clk);
    Evict = 1'b0; VictimWay = '0;
    for (int b = 0; b < 4; b++) begin
      chkbeat("d1.beat", 32'h123450A0 + b*8, wd(1, b, 0), b == 3);
      @(negedge clk);
    end
    chkidle("d1.done");

    // stalled drain of way 2 with array contents changed mid-drain
    VictimWay = 4'b0100; DirtyWay = 4'b0110; CacheSet = 7'h33; Evict = 1'b1;
    @(negedge clk);
    Evict = 1'b0; VictimWay = '0;
    chkbeat("st.b0", 32'h0ABCD660, wd(2, 0, 0), 1'b0);
    TagWay[40 +: 20] = 20'hFFFFF; load(1); CacheSet = 7'h00;
    @(negedge clk);
    chkbeat("st.b1", 32'h0ABCD668, wd(2, 1, 0), 1'b0);
    @(negedge clk);
    chkbeat("st.b2", 32'h0ABCD670, wd(2, 2, 0), 1'b0);
    BusAck = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chkbeat("st.hold", 32'h0ABCD670, wd(2, 2, 0), 1'b0);
    end
    BusAck = 1'b1;
    @(negedge clk);
    chkbeat("st.b3", 32'h0ABCD678, wd(2, 3, 0), 1'b1);
    @(negedge clk);
    chkidle("st.done");

    // busy + probe: drain way 3, request way 0 while busy
    TagWay[40 +: 20] = 20'h0ABCD;
    VictimWay = 4'b1000; DirtyWay = 4'b1000; CacheSet = 7'h7F; Evict = 1'b1;
    @(negedge clk);
    VictimWay = 4'b0001; DirtyWay = 4'b0001; CacheSet = 7'h01; BusAck = 1'b0;
    chkbeat("bp.b0", 32'h00F0FFE0, wd(3, 0, 1), 1'b0);
    #1 chk("bp.dirty", {63'b0, EvictDirty}, 64'd1);
    chk("bp.busy", {63'b0, EvictReady}, 64'd0);
    ProbeAdr = 32'h00F0FFF8;
    #1 chk("bp.hit", {63'b0, ProbeHit}, 64'd1);
    ProbeAdr = 32'h00F0F000;
    #1 chk("bp.miss", {63'b0, ProbeHit}, 64'd0);
    @(negedge clk);
    chkbeat("bp.b0hold", 32'h00F0FFE0, wd(3, 0, 1), 1'b0);
    BusAck = 1'b1; ProbeAdr = 32'h00F0FFE0;
    for (int b = 1; b < 4; b++) begin
      @(negedge clk);
      chkbeat("bp.beat", 32'h00F0FFE0 + b*8, wd(3, b, 1), b == 3);
      chk("bp.hit2", {63'b0, ProbeHit}, 64'd1);
    end
    @(negedge clk);
    chkidle("bp.gap");
    chk("bp.idleprobe", {63'b0, ProbeHit}, 64'd0);
    @(negedge clk);
    Evict = 1'b0;
    chkbeat("bp.new", 32'h11111020, wd(0, 0, 1), 1'b0);
    chk("bp.oldprobe", {63'b0, ProbeHit}, 64'd0);

    // reset after beat 1 acked
    @(negedge clk);
    chkbeat("rm.b1", 32'h11111028, wd(0, 1, 1), 1'b0);
    @(negedge clk);
    reset = 1'b1; BusAck = 1'b0; ProbeAdr = 32'h11111020;
    @(negedge clk);
    chkidle("rm.rst");
    chk("rm.probe", {63'b0, ProbeHit}, 64'd0);
    reset = 1'b0; Evict = 1'b1; BusAck = 1'b1;
    @(negedge clk);
    Evict = 1'b0; VictimWay = '0;
    chkbeat("rm.restart", 32'h11111020, wd(0, 0, 1), 1'b0);
    for (int b = 1; b < 4; b++) begin
      @(negedge clk);
      chkbeat("rm.beat", 32'h11111020 + b*8, wd(0, b, 1), b == 3);
    end
    @(negedge clk);
    chkidle("rm.done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
